// File: rtl/exec_sequencer.sv
// ============================================================================
// exec_sequencer : instruction execute sequencer (IDLE/ALU/MEM/CTRL/HALT).
// Optional MEM_TIMEOUT_EN macro adds a memory-ack watchdog.  Rev 1.0
// ============================================================================
`default_nettype none

module exec_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_instr_valid,
    output logic                o_instr_ready,
    input  logic [1:0]          i_category,
    input  logic [3:0]          i_opcode,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic                i_mem_ack,
    output logic                o_alu_en,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic                o_busy,
    output logic                o_halted,
    output logic                o_mem_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ALU  = 3'd1,
        S_MEM  = 3'd2,
        S_CTRL = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [3:0] c_OP_STORE = 4'b0100;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_opcode;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic                w_accept;
    logic                w_timeout;

    if (MEM_TIMEOUT < 1) begin : g_param_check
        $error("MEM_TIMEOUT must be at least 1");
    end

    assign w_accept = i_instr_valid && o_instr_ready;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_mem_err;

    // Fires on the MEM_TIMEOUT-th ack-less MEM cycle; an ack that same cycle wins.
    assign w_timeout = (r_state == S_MEM) && !i_mem_ack
                       && (r_tmo_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (r_state != S_MEM) begin
                r_tmo_cnt <= '0;
            end else if (!i_mem_ack) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign o_mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign o_mem_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_opcode <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_accept) begin
                r_opcode <= i_opcode;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            S_IDLE: begin
                if (i_instr_valid) begin
                    case (i_category)
                        2'b00:   w_state_next = S_ALU;
                        2'b01:   w_state_next = S_MEM;
                        2'b10:   w_state_next = S_CTRL;
                        default: w_state_next = S_HALT;
                    endcase
                end
            end
            S_ALU: begin
                w_pc_next    = r_pc + 1'b1;
                w_state_next = S_IDLE;
            end
            S_MEM: begin
                if (i_mem_ack) begin
                    w_pc_next    = r_pc + 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_state_next = S_HALT;
                end
            end
            S_CTRL: begin
                w_pc_next    = i_branch_taken ? i_branch_target : r_pc + 1'b1;
                w_state_next = S_IDLE;
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_instr_ready = (r_state == S_IDLE);
    assign o_alu_en      = (r_state == S_ALU);
    assign o_mem_req     = (r_state == S_MEM);
    assign o_mem_we      = (r_state == S_MEM) && (r_opcode == c_OP_STORE);
    assign o_busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign o_halted      = (r_state == S_HALT);
    assign o_pc          = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_exec_sequencer.sv
// ============================================================================
// tb_exec_sequencer : randomized scoreboard bench for exec_sequencer.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exec_sequencer;

    localparam int PCW = 8;
    localparam int TMO = 15;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           i_instr_valid = 1'b0;
    logic           o_instr_ready;
    logic [1:0]     i_category = 2'b00;
    logic [3:0]     i_opcode = 4'h0;
    logic           i_branch_taken = 1'b0;
    logic [PCW-1:0] i_branch_target = '0;
    logic           i_mem_ack = 1'b0;
    logic           o_alu_en;
    logic           o_mem_req;
    logic           o_mem_we;
    logic [PCW-1:0] o_pc;
    logic           o_busy;
    logic           o_halted;
    logic           o_mem_err;

    always #5 clk = ~clk;

    exec_sequencer #(.PC_WIDTH(PCW), .MEM_TIMEOUT(TMO)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_instr_valid   (i_instr_valid),
        .o_instr_ready   (o_instr_ready),
        .i_category      (i_category),
        .i_opcode        (i_opcode),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_mem_ack       (i_mem_ack),
        .o_alu_en        (o_alu_en),
        .o_mem_req       (o_mem_req),
        .o_mem_we        (o_mem_we),
        .o_pc            (o_pc),
        .o_busy          (o_busy),
        .o_halted        (o_halted),
        .o_mem_err       (o_mem_err)
    );

    typedef struct {
        int             kind;   // 0 ALU, 1 MEM, 2 CTRL, 3 HALT
        logic           we;
        logic [PCW-1:0] pc;
        int             cycles;
        logic           abort;
        logic           err;
    } exp_t;

    exp_t           exp_q[$];
    int             checks = 0;
    int             errors = 0;
    logic [PCW-1:0] m_pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Present one instruction, push its expected outcome, then drive its execute phase.
    task automatic issue(input logic [1:0] cat, input logic [3:0] op, input logic tk,
                         input logic [PCW-1:0] tgt, input int d, input bit noack,
                         input bit abort);
        exp_t e;
        int   n;
        i_instr_valid   = 1'b1;
        i_category      = cat;
        i_opcode        = op;
        i_branch_taken  = tk;
        i_branch_target = tgt;
        n = 0;
        while (!o_instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_instr_ready) begin
            chk("ready_wait_expired", {31'd0, o_instr_ready}, 32'd1);
            i_instr_valid = 1'b0;
            return;
        end
        e.kind   = int'(cat);
        e.we     = (op == 4'b0100);
        e.cycles = d + 1;
        e.abort  = abort;
        e.err    = 1'b0;
        case (cat)
            2'b00: m_pc = m_pc + 1;
            2'b01: if (!noack) m_pc = m_pc + 1;
            2'b10: m_pc = tk ? tgt : m_pc + 1;
            default: ;
        endcase
        if (noack) e.cycles = d;
        e.pc = m_pc;
        exp_q.push_back(e);
        if (cat == 2'b01 && noack && !abort) begin
            e.kind = 3;
            e.err  = 1'b1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        i_instr_valid = 1'b0;
        if (cat == 2'b00 || cat == 2'b10) begin
            i_mem_ack = 1'($urandom % 2);
            @(posedge clk);
            #1;
            i_mem_ack = 1'b0;
        end else if (cat == 2'b01) begin
            for (int k = 1; k <= 1000; k++) begin
                bit last;
                last      = noack ? (k == d) : (k == d + 1);
                i_mem_ack = !noack && (k == d + 1);
                @(posedge clk);
                #1;
                if (last) break;
            end
            i_mem_ack = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_pc = '0;
        chk("rst_pc", {24'd0, o_pc}, 32'd0);
        chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_halted", {31'd0, o_halted}, 32'd0);
        chk("rst_mem_err", {31'd0, o_mem_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, o_instr_ready}, 32'd1);
    endtask

    // Monitor: pops one expectation whenever the DUT starts executing or halts.
    initial begin
        exp_t e;
        bit   seen_halt;
        int   n;
        seen_halt = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen_halt = 1'b0;
                continue;
            end
            if (o_busy || (o_halted && !seen_halt)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_activity actual busy=%0b halted=%0b required idle", o_busy, o_halted);
                    continue;
                end
                e = exp_q.pop_front();
                if (e.kind == 3) begin
                    chk("halt_halted", {31'd0, o_halted}, 32'd1);
                    chk("halt_busy", {31'd0, o_busy}, 32'd0);
                    chk("halt_ready", {31'd0, o_instr_ready}, 32'd0);
                    chk("halt_mem_err", {31'd0, o_mem_err}, {31'd0, e.err});
                    chk("halt_pc", {24'd0, o_pc}, {24'd0, e.pc});
                    seen_halt = 1'b1;
                end else begin
                    chk("alu_en", {31'd0, o_alu_en}, {31'd0, e.kind == 0});
                    chk("mem_req", {31'd0, o_mem_req}, {31'd0, e.kind == 1});
                    if (e.kind == 1) begin
                        n = 0;
                        while (o_mem_req && n < 100) begin
                            chk("mem_we", {31'd0, o_mem_we}, {31'd0, e.we});
                            n++;
                            @(negedge clk);
                        end
                        if (!e.abort) begin
                            chk("mem_cycles", n, e.cycles);
                            chk("mem_pc", {24'd0, o_pc}, {24'd0, e.pc});
                        end
                    end else begin
                        chk("nonmem_we", {31'd0, o_mem_we}, 32'd0);
                        @(negedge clk);
                        chk("pc", {24'd0, o_pc}, {24'd0, e.pc});
                        chk("alu_en_drop", {31'd0, o_alu_en}, 32'd0);
                        chk("ready_back", {31'd0, o_instr_ready}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] cat;
        logic [3:0] op;
        #3;
        rst_n = 1'b0;
        #1;
        chk("init_pc", {24'd0, o_pc}, 32'd0);
        chk("init_alu_en", {31'd0, o_alu_en}, 32'd0);
        chk("init_mem_we", {31'd0, o_mem_we}, 32'd0);
        chk("init_busy", {31'd0, o_busy}, 32'd0);
        chk("init_ready", {31'd0, o_instr_ready}, 32'd1);
        do_reset();

        issue(2'b00, 4'h0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        issue(2'b01, 4'b0100, 1'b0, 8'h00, 2, 1'b0, 1'b0);
        issue(2'b01, 4'b0011, 1'b0, 8'h00, 2, 1'b0, 1'b0);
        issue(2'b10, 4'h7, 1'b1, 8'hA5, 0, 1'b0, 1'b0);
        issue(2'b10, 4'h7, 1'b0, 8'h11, 0, 1'b0, 1'b0);
        issue(2'b10, 4'h7, 1'b1, 8'hFF, 0, 1'b0, 1'b0);
        issue(2'b00, 4'h1, 1'b0, 8'h00, 0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            cat = 2'($urandom % 3);
            case ($urandom % 3)
                0:       op = 4'b0100;
                1:       op = 4'b0011;
                default: op = 4'($urandom);
            endcase
            issue(cat, op, 1'($urandom), 8'($urandom), int'($urandom % 7), 1'b0, 1'b0);
        end

`ifdef MEM_TIMEOUT_EN
        issue(2'b01, 4'b0100, 1'b0, 8'h00, TMO - 1, 1'b0, 1'b0);
        chk("late_ack_no_err", {31'd0, o_mem_err}, 32'd0);
        issue(2'b01, 4'b0011, 1'b0, 8'h00, TMO, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_mem_err", {31'd0, o_mem_err}, 32'd1);
        chk("tmo_halted", {31'd0, o_halted}, 32'd1);
        do_reset();
`endif

        issue(2'b00, 4'h2, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        issue(2'b01, 4'b0100, 1'b0, 8'h00, 3, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mem_req_drop", {31'd0, o_mem_req}, 32'd0);
        chk("async_pc_clear", {24'd0, o_pc}, 32'd0);
        m_pc = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_reset_ready", {31'd0, o_instr_ready}, 32'd1);
        issue(2'b00, 4'h0, 1'b0, 8'h00, 0, 1'b0, 1'b0);

        issue(2'b11, 4'h0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
        i_instr_valid = 1'b1;
        i_category    = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        chk("halt_ignores_pc", {24'd0, o_pc}, {24'd0, m_pc});
        chk("halt_ignores_alu", {31'd0, o_alu_en}, 32'd0);
        chk("halt_sticky", {31'd0, o_halted}, 32'd1);
        i_instr_valid = 1'b0;

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
